// File: rtl/spi_link_pkg.sv
// Shared constants and state type for the Kalman filter SPI output link.
package spi_link_pkg;

  localparam int unsigned WORD_W     = 16;
  localparam logic [15:0] WAIT_WORD  = 16'hFFFF;
  localparam int unsigned XFER_RISES = 17;

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    DONE,
    GAP
  } reader_state_t;

endpackage

// File: rtl/sck_gen.sv
// Free-running SPI clock generator with single-cycle edge strobes.
// The strobes are asserted in the clk cycle whose edge drives the SCK transition.
module sck_gen #(
  parameter int unsigned SCK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  output logic sck,
  output logic rise_c,
  output logic fall_c
);

  localparam int unsigned    CNT_W    = $clog2(SCK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCK_DIV - 1);

  logic [CNT_W-1:0] cnt;
  logic             toggle_c;

  assign toggle_c = (cnt == CNT_LAST);
  assign rise_c   = toggle_c & ~sck;
  assign fall_c   = toggle_c & sck;

  // Half-period counter; SCK flips every SCK_DIV clks in every reader state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      sck <= 1'b0;
    end else if (toggle_c) begin
      cnt <= '0;
      sck <= ~sck;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/spi_word_reader.sv
// Master-side SPI word receiver for the Kalman filter output link.
// Generates SCK/CS, samples MISO MSB-first and presents each word in parallel.
module spi_word_reader #(
  parameter int unsigned SCK_DIV     = 4,
  parameter int unsigned WORD_W      = 16,
  parameter int unsigned GAP_PERIODS = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              rpi_sck,
  output logic              rpi_cs,
  input  logic              rpi_miso,
  output logic [WORD_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              rx_waiting,
  output logic              busy
);

  import spi_link_pkg::*;

  localparam int unsigned      GAP_W     = $clog2(GAP_PERIODS + 1);
  localparam logic [4:0]       RISE_LAST = 5'(XFER_RISES);
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP_PERIODS);

  logic              rise_c;
  logic              fall_c;
  logic              miso_q;
  reader_state_t     state;
  logic [4:0]        rise_cnt;
  logic [GAP_W-1:0]  gap_cnt;
  logic [WORD_W-1:0] shift_reg;

  sck_gen #(
    .SCK_DIV (SCK_DIV)
  ) u_sck_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .sck    (rpi_sck),
    .rise_c (rise_c),
    .fall_c (fall_c)
  );

  // Single register stage on the slave data before it is sampled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      miso_q <= 1'b1;
    end else begin
      miso_q <= rpi_miso;
    end
  end

  // Transaction FSM. IDLE also serves as the post-reset hold: gap_cnt starts
  // at zero, so the slave sees CS high for GAP_PERIODS rises before any start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rpi_cs     <= 1'b1;
      rx_data    <= WORD_W'(WAIT_WORD);
      rx_valid   <= 1'b0;
      rx_waiting <= 1'b0;
      busy       <= 1'b0;
      rise_cnt   <= '0;
      gap_cnt    <= '0;
      shift_reg  <= '0;
    end else begin
      rx_valid   <= 1'b0;
      rx_waiting <= 1'b0;
      case (state)
        IDLE: begin
          if (rise_c && (gap_cnt != GAP_LAST)) begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
          if (fall_c && start && (gap_cnt == GAP_LAST)) begin
            rpi_cs   <= 1'b0;
            busy     <= 1'b1;
            rise_cnt <= '0;
            state    <= XFER;
          end
        end
        XFER: begin
          if (rise_c && (rise_cnt != RISE_LAST)) begin
            rise_cnt <= rise_cnt + 5'd1;
          end
          if (fall_c) begin
            if (rise_cnt == RISE_LAST) begin
              rpi_cs <= 1'b1;
              state  <= DONE;
            end else if (rise_cnt != 5'd0) begin
              shift_reg <= {shift_reg[WORD_W-2:0], miso_q};
            end
          end
        end
        DONE: begin
          rx_data    <= shift_reg;
          rx_valid   <= 1'b1;
          rx_waiting <= (shift_reg == WORD_W'(WAIT_WORD));
          gap_cnt    <= '0;
          state      <= GAP;
        end
        GAP: begin
          if (rise_c && (gap_cnt != GAP_LAST)) begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
          if (fall_c && (gap_cnt == GAP_LAST)) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_word_reader.sv
// Self-checking bench for spi_word_reader: slave model, link monitor,
// vector table, randomized words and hand-written corner sequences.
module tb_spi_word_reader;

  localparam int unsigned DIV_A = 4;
  localparam int unsigned DIV_B = 2;
  localparam int unsigned GAPP  = 2;
  localparam int unsigned RISES = 17;
  localparam int          LAT_A = 2 * RISES * DIV_A + 1;

  typedef struct {
    logic        load;
    logic [15:0] word;
    logic [15:0] exp_data;
    logic        exp_wait;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;

  logic        start;
  logic        rpi_sck;
  logic        rpi_cs;
  logic        rpi_miso = 1'b1;
  logic [15:0] rx_data;
  logic        rx_valid;
  logic        rx_waiting;
  logic        busy;

  logic        start_b;
  logic        rpi_sck_b;
  logic        rpi_cs_b;
  logic        rpi_miso_b = 1'b1;
  logic [15:0] rx_data_b;
  logic        rx_valid_b;
  logic        rx_waiting_b;
  logic        busy_b;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  spi_word_reader #(.SCK_DIV(DIV_A), .WORD_W(16), .GAP_PERIODS(GAPP)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .rpi_sck(rpi_sck), .rpi_cs(rpi_cs),
    .rpi_miso(rpi_miso), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_waiting(rx_waiting), .busy(busy)
  );

  spi_word_reader #(.SCK_DIV(DIV_B), .WORD_W(16), .GAP_PERIODS(GAPP)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .rpi_sck(rpi_sck_b), .rpi_cs(rpi_cs_b),
    .rpi_miso(rpi_miso_b), .rx_data(rx_data_b), .rx_valid(rx_valid_b),
    .rx_waiting(rx_waiting_b), .busy(busy_b)
  );

  task automatic check(input bit ok, input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
    end
  endtask

  // Slave word queue (what the slave will send) and reference queue (what
  // each completed transaction must deliver; empty means 0xFFFF).
  logic [15:0] sq_a[$];
  logic [15:0] exp_q[$];
  logic [15:0] sq_b[$];

  // Slave A: detects CS low at a rise, presents bit (16-k) after rise k,
  // retires its word only at the 17th rise.
  logic [15:0] sw_a;
  int          sc_a = 0;
  always @(posedge rpi_sck) begin
    if (rpi_cs) begin
      sc_a = 0;
    end else begin
      sc_a++;
      if (sc_a == 1) sw_a = (sq_a.size() > 0) ? sq_a[0] : 16'hFFFF;
      if (sc_a <= 16) begin
        rpi_miso = sw_a[4'(16 - sc_a)];
      end else begin
        rpi_miso = 1'b1;
        if (sc_a == 17 && sq_a.size() > 0) sw_a = sq_a.pop_front();
      end
    end
  end

  // Slave B: same behaviour on the fast-SCK instance.
  logic [15:0] sw_b;
  int          sc_b = 0;
  always @(posedge rpi_sck_b) begin
    if (rpi_cs_b) begin
      sc_b = 0;
    end else begin
      sc_b++;
      if (sc_b == 1) sw_b = (sq_b.size() > 0) ? sq_b[0] : 16'hFFFF;
      if (sc_b <= 16) begin
        rpi_miso_b = sw_b[4'(16 - sc_b)];
      end else begin
        rpi_miso_b = 1'b1;
        if (sc_b == 17 && sq_b.size() > 0) sw_b = sq_b.pop_front();
      end
    end
  end

  // Link monitor for instance A: CS framing, gap length, data and latency.
  int          cyc = 0;
  logic        sck_prev = 1'b0;
  logic        cs_prev = 1'b1;
  int          low_rises = 0;
  int          high_rises = 0;
  int          last_gap = 0;
  int          cs_fall_cyc = 0;
  int          n_cs_fall = 0;
  int          n_valid = 0;
  logic [15:0] last_data = 16'h0;
  logic        last_wait = 1'b0;
  always @(negedge clk) begin
    logic [15:0] e;
    cyc++;
    if (!rst_n) begin
      sck_prev   = 1'b0;
      cs_prev    = 1'b1;
      low_rises  = 0;
      high_rises = 0;
    end else begin
      if (rpi_sck && !sck_prev) begin
        if (rpi_cs) high_rises++;
        else        low_rises++;
      end
      if (!rpi_cs && cs_prev) begin
        check(high_rises >= int'(GAPP), "cs_gap_min", 32'(high_rises), 32'(GAPP));
        last_gap    = high_rises;
        low_rises   = 0;
        cs_fall_cyc = cyc;
        n_cs_fall++;
      end
      if (rpi_cs && !cs_prev) begin
        check(low_rises == int'(RISES), "cs_low_rises", 32'(low_rises), 32'(RISES));
        high_rises = 0;
      end
      if (rx_valid) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hFFFF;
        n_valid++;
        check(rx_data === e, "rx_data", 32'(rx_data), 32'(e));
        check(rx_waiting === (e == 16'hFFFF), "rx_waiting", 32'(rx_waiting),
              32'(e == 16'hFFFF));
        check(cyc - cs_fall_cyc == LAT_A, "latency", 32'(cyc - cs_fall_cyc), 32'(LAT_A));
        last_data = rx_data;
        last_wait = rx_waiting;
      end else if (rx_waiting) begin
        check(1'b0, "waiting_without_valid", 32'(rx_waiting), 32'd0);
      end
      sck_prev = rpi_sck;
      cs_prev  = rpi_cs;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic load(input logic [15:0] w);
    sq_a.push_back(w);
    exp_q.push_back(w);
  endtask

  task automatic wait_busy(input logic lvl, input int lim, input string nm);
    for (int i = 0; i < lim && busy !== lvl; i++) tick();
    check(busy === lvl, nm, 32'(busy), 32'(lvl));
  endtask

  task automatic run_txn(input logic [15:0] w, input bit ld);
    int base;
    base = n_valid;
    if (ld) load(w);
    start = 1'b1;
    wait_busy(1'b1, 200, "txn_start");
    start = 1'b0;
    for (int i = 0; i < 600 && n_valid == base; i++) tick();
    wait_busy(1'b0, 200, "txn_end");
    check(n_valid == base + 1, "txn_valid_count", 32'(n_valid - base), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t vec[6];
    int   base;
    int   cf;
    bit   drop;
    int   t0;
    int   t1;
    logic p;
    bit   got;

    vec[0] = '{1'b1, 16'hA5C3, 16'hA5C3, 1'b0};
    vec[1] = '{1'b0, 16'h0000, 16'hFFFF, 1'b1};
    vec[2] = '{1'b1, 16'h0000, 16'h0000, 1'b0};
    vec[3] = '{1'b1, 16'hFFFF, 16'hFFFF, 1'b1};
    vec[4] = '{1'b1, 16'h8001, 16'h8001, 1'b0};
    vec[5] = '{1'b1, 16'h7FFE, 16'h7FFE, 1'b0};

    rst_n   = 1'b0;
    start   = 1'b0;
    start_b = 1'b0;
    repeat (3) tick();

    check(rpi_sck === 1'b0, "rst_sck", 32'(rpi_sck), 32'd0);
    check(rpi_cs === 1'b1, "rst_cs", 32'(rpi_cs), 32'd1);
    check(rx_data === 16'hFFFF, "rst_rx_data", 32'(rx_data), 32'hFFFF);
    check(rx_valid === 1'b0, "rst_rx_valid", 32'(rx_valid), 32'd0);
    check(rx_waiting === 1'b0, "rst_rx_waiting", 32'(rx_waiting), 32'd0);
    check(busy === 1'b0, "rst_busy", 32'(busy), 32'd0);
    check(rx_data_b === 16'hFFFF, "rst_rx_data_b", 32'(rx_data_b), 32'hFFFF);
    rst_n = 1'b1;

    // Vector table
    for (int i = 0; i < 6; i++) begin
      run_txn(vec[i].word, vec[i].load);
      check(last_data === vec[i].exp_data, "vec_data", 32'(last_data), 32'(vec[i].exp_data));
      check(last_wait === vec[i].exp_wait, "vec_wait", 32'(last_wait), 32'(vec[i].exp_wait));
    end

    // Randomized words, some transactions with the slave holding no data
    for (int i = 0; i < 8; i++) begin
      logic [15:0] w;
      bit          ld;
      logic [15:0] ex;
      w  = 16'($urandom);
      ld = ($urandom_range(3) != 0);
      ex = ld ? w : 16'hFFFF;
      run_txn(w, ld);
      check(last_data === ex, "rand_data", 32'(last_data), 32'(ex));
      check(last_wait === (ex == 16'hFFFF), "rand_wait", 32'(last_wait), 32'(ex == 16'hFFFF));
    end

    // start held high: two back-to-back transactions
    base = n_valid;
    load(16'h0001);
    load(16'h8000);
    start = 1'b1;
    for (int i = 0; i < 2000 && n_valid < base + 2; i++) tick();
    start = 1'b0;
    check(n_valid == base + 2, "b2b_valids", 32'(n_valid - base), 32'd2);
    check(last_gap >= int'(GAPP), "b2b_gap", 32'(last_gap), 32'(GAPP));
    check(last_data === 16'h8000, "b2b_second_word", 32'(last_data), 32'h8000);
    wait_busy(1'b0, 400, "b2b_idle");

    // start pulsed at rise 5 of a transfer is ignored
    base = n_valid;
    cf   = n_cs_fall;
    load(16'h3C3C);
    start = 1'b1;
    wait_busy(1'b1, 200, "ign_busy_up");
    start = 1'b0;
    for (int i = 0; i < 500 && low_rises < 5; i++) tick();
    check(low_rises == 5, "ign_at_rise5", 32'(low_rises), 32'd5);
    start = 1'b1;
    tick();
    start = 1'b0;
    drop = 1'b0;
    for (int i = 0; i < 500 && n_valid == base; i++) begin
      if (!busy) drop = 1'b1;
      tick();
    end
    check(drop == 1'b0, "ign_busy_held", 32'(drop), 32'd0);
    wait_busy(1'b0, 200, "ign_idle");
    repeat (120) tick();
    check(n_valid == base + 1, "ign_valid_count", 32'(n_valid - base), 32'd1);
    check(n_cs_fall == cf + 1, "ign_cs_falls", 32'(n_cs_fall - cf), 32'd1);

    // Reset asserted at rise 9, then a clean transfer after release
    base = n_valid;
    load(16'h1234);
    start = 1'b1;
    wait_busy(1'b1, 200, "rst_txn_start");
    start = 1'b0;
    for (int i = 0; i < 500 && low_rises < 9; i++) tick();
    check(low_rises == 9, "rst_at_rise9", 32'(low_rises), 32'd9);
    rst_n = 1'b0;
    #1;
    check(rpi_cs === 1'b1, "abort_cs", 32'(rpi_cs), 32'd1);
    check(rpi_sck === 1'b0, "abort_sck", 32'(rpi_sck), 32'd0);
    check(rx_valid === 1'b0, "abort_rx_valid", 32'(rx_valid), 32'd0);
    check(busy === 1'b0, "abort_busy", 32'(busy), 32'd0);
    repeat (3) tick();
    start = 1'b1;
    rst_n = 1'b1;
    wait_busy(1'b1, 300, "rst_restart");
    start = 1'b0;
    check(last_gap >= int'(GAPP), "rst_hold_rises", 32'(last_gap), 32'(GAPP));
    for (int i = 0; i < 600 && n_valid == base; i++) tick();
    check(n_valid == base + 1, "rst_valid_count", 32'(n_valid - base), 32'd1);
    check(last_data === 16'h1234, "rst_word", 32'(last_data), 32'h1234);
    wait_busy(1'b0, 200, "rst_idle");

    // SCK_DIV=2 instance: period and one word
    p  = rpi_sck_b;
    t0 = -1;
    t1 = -1;
    for (int i = 0; i < 50 && t1 < 0; i++) begin
      tick();
      if (rpi_sck_b && !p) begin
        if (t0 < 0) t0 = cyc;
        else        t1 = cyc;
      end
      p = rpi_sck_b;
    end
    check(t1 - t0 == 2 * int'(DIV_B), "b_sck_period", 32'(t1 - t0), 32'(2 * DIV_B));
    sq_b.push_back(16'h5A5A);
    start_b = 1'b1;
    for (int i = 0; i < 200 && !busy_b; i++) tick();
    check(busy_b === 1'b1, "b_start", 32'(busy_b), 32'd1);
    start_b = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 400 && !got; i++) begin
      tick();
      if (rx_valid_b) got = 1'b1;
    end
    check(got, "b_rx_valid", 32'(got), 32'd1);
    check(rx_data_b === 16'h5A5A, "b_rx_data", 32'(rx_data_b), 32'h5A5A);
    check(rx_waiting_b === 1'b0, "b_rx_waiting", 32'(rx_waiting_b), 32'd0);

    repeat (5) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
